// File: rtl/crypto_ctrl_pkg.sv
// Shared types and constants for the crypto control unit: FSM state encoding and
// host status-word bit positions.
package crypto_ctrl_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StKeyLoad,
        StKeySettle,
        StEncrypt,
        StDecrypt,
        StGetData,
        StDidRead,
        StFixRx,
        StEnqTx,
        StTxStall
    } ctrl_state_e;

    localparam int unsigned STATUS_W = 6;

    localparam int unsigned ST_RX_FULL   = 0;
    localparam int unsigned ST_TX_NEMPTY = 1;
    localparam int unsigned ST_DEC       = 2;
    localparam int unsigned ST_ENC       = 3;
    localparam int unsigned ST_KEY       = 4;
    localparam int unsigned ST_ERR       = 5;

endpackage

// File: rtl/crypto_ctrl_fsm_key_load_seq.sv
// Key-load sequencer: counts KEY_WORDS key-FIFO reads, then KEY_SETTLE idle cycles.
// The FSM pulses start on entry to the load and watches the two done flags.
module key_load_seq #(
    parameter int unsigned KEY_WORDS  = 4,
    parameter int unsigned KEY_SETTLE = 3
) (
    input  logic clk,
    input  logic n_reset,
    input  logic start,
    input  logic load_active,
    input  logic settle_active,
    output logic words_done,
    output logic settle_done
);

    localparam int unsigned WORD_W   = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam int unsigned SETTLE_W = (KEY_SETTLE > 1) ? $clog2(KEY_SETTLE) : 1;

    localparam logic [WORD_W-1:0]   WORD_LAST   = WORD_W'(KEY_WORDS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        SETTLE_W'((KEY_SETTLE > 0) ? KEY_SETTLE - 1 : 0);

    logic [WORD_W-1:0]   word_cnt_q;
    logic [SETTLE_W-1:0] settle_cnt_q;

    assign words_done  = load_active && (word_cnt_q == WORD_LAST);
    assign settle_done = settle_active && (settle_cnt_q == SETTLE_LAST);

    always_ff @(posedge clk) begin
        if (!n_reset || start) begin
            word_cnt_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            if (load_active) begin
                word_cnt_q <= words_done ? '0 : word_cnt_q + 1'b1;
            end
            if (settle_active) begin
                settle_cnt_q <= settle_done ? '0 : settle_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/crypto_ctrl_fsm.sv
// Master control FSM for the UART encrypt/decrypt datapath.
// Define CRYPTO_REKEY_EN to allow reloading the key after key_ready is set.
module crypto_ctrl_fsm
    import crypto_ctrl_pkg::*;
#(
    parameter int unsigned KEY_WORDS  = 4,
    parameter int unsigned KEY_SETTLE = 3,
    parameter int unsigned RETRY_MAX  = 7,
    parameter int unsigned ERR_W      = 4
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                key_in,
    input  logic                enc_req,
    input  logic                dec_req,
    input  logic                rx_empty,
    input  logic                rx_full,
    input  logic                tx_empty,
    input  logic                tx_full,
    input  logic                framing_error,
    input  logic                data_done,
    input  logic                accepted,
    output logic                is_encrypt,
    output logic                is_decrypt,
    output logic                read_fifo,
    output logic                rcv_deq,
    output logic                fix_error,
    output logic                trans_enq,
    output logic                read_fifo_keygen,
    output logic                key_ready,
    output logic [ERR_W-1:0]    err_count,
    output logic [STATUS_W-1:0] status_bits
);

    localparam int unsigned    RETRY_W    = $clog2(RETRY_MAX + 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX - 1);

    ctrl_state_e        state_q, state_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               key_ready_q, key_ready_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic key_start;
    logic words_done;
    logic settle_done;
    logic key_allowed;

`ifdef CRYPTO_REKEY_EN
    assign key_allowed = key_in;
`else
    assign key_allowed = key_in && !key_ready_q;
`endif

    key_load_seq #(
        .KEY_WORDS  (KEY_WORDS),
        .KEY_SETTLE (KEY_SETTLE)
    ) u_key_load_seq (
        .clk           (clk),
        .n_reset       (n_reset),
        .start         (key_start),
        .load_active   (state_q == StKeyLoad),
        .settle_active (state_q == StKeySettle),
        .words_done    (words_done),
        .settle_done   (settle_done)
    );

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            retry_q     <= '0;
            key_ready_q <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            key_ready_q <= key_ready_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        key_start = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (data_done) begin
                    state_d = tx_full ? StTxStall : StEnqTx;
                end else if (!rx_empty && !framing_error) begin
                    state_d = StGetData;
                end else if (enc_req && key_ready_q) begin
                    state_d = StEncrypt;
                end else if (dec_req && key_ready_q) begin
                    state_d = StDecrypt;
                end else if (key_allowed) begin
                    state_d   = StKeyLoad;
                    key_start = 1'b1;
                end
            end
            StKeyLoad: begin
                if (words_done) begin
                    state_d = (KEY_SETTLE == 0) ? StIdle : StKeySettle;
                end
            end
            StKeySettle: begin
                if (settle_done) begin
                    state_d = StIdle;
                end
            end
            StEncrypt, StDecrypt, StFixRx: begin
                state_d = StIdle;
            end
            StGetData: begin
                state_d = framing_error ? StFixRx : StDidRead;
            end
            StDidRead: begin
                if (accepted) begin
                    retry_d = '0;
                    state_d = StIdle;
                end else if (retry_q == RETRY_LAST) begin
                    retry_d = '0;
                    state_d = StFixRx;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = StGetData;
                end
            end
            StTxStall: begin
                if (!tx_full) begin
                    state_d = StEnqTx;
                end
            end
            StEnqTx: begin
                // A late tx_full suppresses the enqueue; retry it from the stall state.
                state_d = tx_full ? StTxStall : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        key_ready_d = key_ready_q;
        err_d       = err_q;

        if (state_d == StIdle && (state_q == StKeyLoad || state_q == StKeySettle)) begin
            key_ready_d = 1'b1;
        end
`ifdef CRYPTO_REKEY_EN
        if (key_start) begin
            key_ready_d = 1'b0;
        end
`endif
        // FixRx always returns to Idle, so this fires exactly once per entry.
        if (state_d == StFixRx && err_q != '1) begin
            err_d = err_q + 1'b1;
        end
    end

    always_comb begin
        read_fifo_keygen = (state_q == StKeyLoad);
        is_encrypt       = (state_q == StEncrypt);
        is_decrypt       = (state_q == StDecrypt);
        read_fifo        = (state_q == StGetData);
        rcv_deq          = (state_q == StDidRead) && accepted;
        fix_error        = (state_q == StFixRx);
        trans_enq        = (state_q == StEnqTx) && !tx_full;
        key_ready        = key_ready_q;
        err_count        = err_q;
    end

    always_comb begin
        status_bits               = '0;
        status_bits[ST_RX_FULL]   = rx_full;
        status_bits[ST_TX_NEMPTY] = !tx_empty;
        status_bits[ST_DEC]       = is_decrypt;
        status_bits[ST_ENC]       = is_encrypt;
        status_bits[ST_KEY]       = key_ready_q;
        status_bits[ST_ERR]       = (err_q != '0);
    end

endmodule
